// File: rtl/traffic_pkg.sv
// Shared constants for the traffic light controller: the one-hot light encoding,
// the default phase durations, and the default clock rate.
// traffic_fsm and traffic_timer both import this package.
package traffic_pkg;

    localparam int unsigned LIGHT_STATE_WIDTH = 3;

    typedef logic [LIGHT_STATE_WIDTH-1:0] light_state_t;

    localparam light_state_t LIGHT_GREEN  = 3'b001;
    localparam light_state_t LIGHT_YELLOW = 3'b010;
    localparam light_state_t LIGHT_RED    = 3'b100;

    localparam int unsigned GREEN_SEC_DEFAULT   = 30;
    localparam int unsigned YELLOW_SEC_DEFAULT  = 3;
    localparam int unsigned RED_SEC_DEFAULT     = 20;
    localparam int unsigned CLK_PER_SEC_DEFAULT = 50000000;

endpackage

// File: rtl/traffic_timer_if.sv
// FSM <-> timer link.
// The FSM (master) drives the enable and the per-phase load request.
// The timer (slave) returns the two terminal flags.
interface traffic_timer_if;
    import traffic_pkg::*;

    logic         en;
    light_state_t light_cnt_init;
    logic         light_cnt_last;
    logic         second_cnt_pre_last;

    modport master (
        output en,
        output light_cnt_init,
        input  light_cnt_last,
        input  second_cnt_pre_last
    );

    modport slave (
        input  en,
        input  light_cnt_init,
        output light_cnt_last,
        output second_cnt_pre_last
    );

endinterface

// File: rtl/sec_prescaler.sv
// Clock-to-second prescaler.
// sec_cnt runs 0..CLK_PER_SEC-1 while enabled and freezes when disabled.
// clr_i restarts the count at 0 and wins over counting.
module sec_prescaler #(
    parameter int unsigned CLK_PER_SEC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o,
    output logic pre_last_o
);

    localparam int unsigned CntW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CntW-1:0] CntLast    = CntW'(CLK_PER_SEC - 1);
    localparam logic [CntW-1:0] CntPreLast = CntW'(CLK_PER_SEC - 2);

    logic [CntW-1:0] sec_cnt_q, sec_cnt_d;

    // Prescaler state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt_q <= '0;
        end else begin
            sec_cnt_q <= sec_cnt_d;
        end
    end

    // Next count: clear, wrap at the last cycle of the second, or hold while disabled.
    always_comb begin
        sec_cnt_d = sec_cnt_q;
        if (clr_i) begin
            sec_cnt_d = '0;
        end else if (en_i) begin
            sec_cnt_d = (sec_cnt_q == CntLast) ? '0 : sec_cnt_q + CntW'(1);
        end
    end

    // Flags are decoded straight from the register, gated by enable.
    always_comb begin
        tick_o     = en_i && (sec_cnt_q == CntLast);
        pre_last_o = en_i && (sec_cnt_q == CntPreLast);
    end

endmodule

// File: rtl/traffic_timer.sv
// Timing back-end for traffic_fsm.
// A valid one-hot load request restarts the prescaler and loads the phase's
// seconds counter with duration-1. The counter then counts down once per second
// and saturates at 0.
// Optional feature, macro TRAFFIC_TIMER_REMAIN_EN: adds the remain_sec
// countdown-display output.
module traffic_timer
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_PER_SEC = CLK_PER_SEC_DEFAULT,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned GREEN_SEC   = GREEN_SEC_DEFAULT,
    parameter int unsigned YELLOW_SEC  = YELLOW_SEC_DEFAULT,
    parameter int unsigned RED_SEC     = RED_SEC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_timer_if.slave       bus
`ifdef TRAFFIC_TIMER_REMAIN_EN
    ,
    output logic [CNT_WIDTH-1:0] remain_sec
`endif
);

    // Reject parameter sets that cannot be counted at this width.
    if (CLK_PER_SEC < 2) begin : g_bad_clk_per_sec
        $error("traffic_timer: CLK_PER_SEC must be >= 2");
    end
    if (GREEN_SEC < 1 || ((GREEN_SEC - 1) >> CNT_WIDTH) != 0) begin : g_bad_green
        $error("traffic_timer: GREEN_SEC out of range for CNT_WIDTH");
    end
    if (YELLOW_SEC < 1 || ((YELLOW_SEC - 1) >> CNT_WIDTH) != 0) begin : g_bad_yellow
        $error("traffic_timer: YELLOW_SEC out of range for CNT_WIDTH");
    end
    if (RED_SEC < 1 || ((RED_SEC - 1) >> CNT_WIDTH) != 0) begin : g_bad_red
        $error("traffic_timer: RED_SEC out of range for CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] GreenLoad  = CNT_WIDTH'(GREEN_SEC - 1);
    localparam logic [CNT_WIDTH-1:0] YellowLoad = CNT_WIDTH'(YELLOW_SEC - 1);
    localparam logic [CNT_WIDTH-1:0] RedLoad    = CNT_WIDTH'(RED_SEC - 1);

    logic [CNT_WIDTH-1:0] light_cnt_q, light_cnt_d;
    logic                 active_q, active_d;
    logic                 load;
    logic [CNT_WIDTH-1:0] load_val;
    logic                 tick;
    logic                 pre_last;

    sec_prescaler #(
        .CLK_PER_SEC (CLK_PER_SEC)
    ) u_sec_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (bus.en),
        .clr_i      (load),
        .tick_o     (tick),
        .pre_last_o (pre_last)
    );

    // Decode the load request; zero-hot and multi-hot patterns are not loads.
    always_comb begin
        load     = 1'b1;
        load_val = '0;
        case (bus.light_cnt_init)
            LIGHT_GREEN:  load_val = GreenLoad;
            LIGHT_YELLOW: load_val = YellowLoad;
            LIGHT_RED:    load_val = RedLoad;
            default:      load     = 1'b0;
        endcase
    end

    // Seconds counter and phase-active registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            light_cnt_q <= '0;
            active_q    <= 1'b0;
        end else begin
            light_cnt_q <= light_cnt_d;
            active_q    <= active_d;
        end
    end

    // Load beats tick and enable.
    // Otherwise decrement once per second, saturating at 0.
    always_comb begin
        light_cnt_d = light_cnt_q;
        active_d    = active_q;
        if (load) begin
            light_cnt_d = load_val;
            active_d    = 1'b1;
        end else if (tick && (light_cnt_q != '0)) begin
            light_cnt_d = light_cnt_q - CNT_WIDTH'(1);
        end
    end

    // Terminal flags seen by the FSM; both are forced low while disabled.
    always_comb begin
        bus.light_cnt_last      = bus.en && active_q && (light_cnt_q == '0);
        bus.second_cnt_pre_last = pre_last;
    end

`ifdef TRAFFIC_TIMER_REMAIN_EN
    // Whole seconds left in the phase, including the running one.
    always_comb begin
        remain_sec = active_q ? light_cnt_q + CNT_WIDTH'(1) : '0;
    end
`endif

endmodule

// File: tb/tb_traffic_timer.sv
// Bench for traffic_timer: constant vector table, directed corner sequences,
// and randomized traffic against a cycle-count reference model.
module tb_traffic_timer;

    localparam int CPS = 4;
    localparam int GS  = 3;
    localparam int YS  = 1;
    localparam int RS  = 2;
    localparam int CW  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    traffic_timer_if bus ();

`ifdef TRAFFIC_TIMER_REMAIN_EN
    logic [CW-1:0] remain_sec;
`endif

    traffic_timer #(
        .CLK_PER_SEC (CPS),
        .CNT_WIDTH   (CW),
        .GREEN_SEC   (GS),
        .YELLOW_SEC  (YS),
        .RED_SEC     (RS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef TRAFFIC_TIMER_REMAIN_EN
        ,
        .remain_sec (remain_sec)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model:
    // - m_cnt counts enabled cycles since the last load or reset.
    // - Seconds left is the duration minus the whole seconds elapsed,
    //   floored at 0.
    int m_cnt = 0;
    bit m_act = 1'b0;
    int m_dur = 0;

    function automatic int dur_of(input logic [2:0] r);
        case (r)
            3'b001:  return GS;
            3'b010:  return YS;
            3'b100:  return RS;
            default: return 0;
        endcase
    endfunction

    function automatic int m_left();
        int r;
        r = m_dur - 1 - (m_cnt / CPS);
        return (r < 0) ? 0 : r;
    endfunction

    function automatic int exp_pre();
        return (bus.en && (m_cnt % CPS == CPS - 2)) ? 1 : 0;
    endfunction

    function automatic int exp_last();
        return (bus.en && m_act && m_left() == 0) ? 1 : 0;
    endfunction

    function automatic int exp_remain();
        return m_act ? m_left() + 1 : 0;
    endfunction

    task automatic model_clock();
        if (dur_of(bus.light_cnt_init) != 0) begin
            m_cnt = 0;
            m_act = 1'b1;
            m_dur = dur_of(bus.light_cnt_init);
        end else if (bus.en) begin
            m_cnt++;
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_act = 1'b0;
        m_dur = 0;
    endtask

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive inputs (called at negedge), let them settle, compare against the model.
    task automatic drive_check(input logic e, input logic [2:0] r, input string tag);
        bus.en = e;
        bus.light_cnt_init = r;
        #1;
        check({tag, ".last"}, bus.light_cnt_last, exp_last());
        check({tag, ".pre"}, bus.second_cnt_pre_last, exp_pre());
`ifdef TRAFFIC_TIMER_REMAIN_EN
        check({tag, ".remain"}, remain_sec, exp_remain());
`endif
    endtask

    task automatic clock();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic step(input logic e, input logic [2:0] r, input string tag);
        drive_check(e, r, tag);
        clock();
    endtask

    // Reset asserted between edges.
    // The outputs must drop immediately, without waiting for a clock.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check({tag, ".rst_last"}, bus.light_cnt_last, 0);
        check({tag, ".rst_pre"}, bus.second_cnt_pre_last, 0);
`ifdef TRAFFIC_TIMER_REMAIN_EN
        check({tag, ".rst_remain"}, remain_sec, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic [2:0] init;
        logic       last;
        logic       pre;
        int         remain;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] bad_pats [4];
        logic [2:0] r;

        bus.en = 1'b1;
        bus.light_cnt_init = 3'b000;

        // GREEN, then YELLOW, then RED loaded on the tick edge, then saturation.
        // Fields: {en, init, last, pre, remain}
        tbl.push_back('{1'b1, 3'b001, 1'b0, 1'b0, 0});  // load GREEN
        tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 3});  // G0
        tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 3});
        tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b1, 3});  // G2
        tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 3});
        tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 2});  // G4
        tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 2});
        tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b1, 2});
        tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 2});
        tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b0, 1});  // G8
        tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b0, 1});
        tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b1, 1});  // G10, both flags
        tbl.push_back('{1'b1, 3'b010, 1'b1, 1'b0, 1});  // G11, request YELLOW
        tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b0, 1});  // Y0
        tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b0, 1});
        tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b1, 1});  // Y2
        tbl.push_back('{1'b1, 3'b100, 1'b1, 1'b0, 1});  // Y3, request RED on tick
        tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 2});  // R0
        tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 2});
        tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b1, 2});
        tbl.push_back('{1'b1, 3'b000, 1'b0, 1'b0, 2});
        tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b0, 1});  // R4
        tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b0, 1});
        tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b1, 1});  // R6
        tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b0, 1});
        tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b0, 1});  // R8, saturated
        tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b0, 1});
        tbl.push_back('{1'b1, 3'b000, 1'b1, 1'b1, 1});  // R10

        // Reset held from time 0, then idle with the prescaler running.
        @(negedge clk);
        check("init.last", bus.light_cnt_last, 0);
        check("init.pre", bus.second_cnt_pre_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 3'b000, "idle");

        // Constant vector table.
        for (int i = 0; i < tbl.size(); i++) begin
            drive_check(tbl[i].en, tbl[i].init, $sformatf("model%0d", i));
            check($sformatf("tbl%0d.last", i), bus.light_cnt_last, tbl[i].last);
            check($sformatf("tbl%0d.pre", i), bus.second_cnt_pre_last, tbl[i].pre);
`ifdef TRAFFIC_TIMER_REMAIN_EN
            check($sformatf("tbl%0d.remain", i), remain_sec, tbl[i].remain);
`endif
            clock();
        end

        // Mid-phase reset while light_cnt_last is high.
        // Afterwards there is no last flag until a load.
        async_reset("midphase");
        for (int i = 0; i < 6; i++) step(1'b1, 3'b000, "postrst");

        // RED load coincident with a tick; m_cnt is 6 here, so one step reaches sec_cnt=3.
        step(1'b1, 3'b000, "prio.pre");
        step(1'b1, 3'b100, "prio.load");
        step(1'b1, 3'b000, "prio.c0");
        step(1'b1, 3'b000, "prio.c1");
        drive_check(1'b1, 3'b000, "prio.c2");
        check("prio.pre_c2", bus.second_cnt_pre_last, 1);
        clock();
        step(1'b1, 3'b000, "prio.c3");
        drive_check(1'b1, 3'b000, "prio.c4");
        check("prio.last_c4", bus.light_cnt_last, 1);
        clock();

        // Multi-hot requests are ignored in the middle of a GREEN phase.
        step(1'b1, 3'b001, "inv.load");
        step(1'b1, 3'b000, "inv.c0");
        step(1'b1, 3'b011, "inv.c1");
        step(1'b1, 3'b111, "inv.c2");
        for (int i = 3; i < 8; i++) step(1'b1, 3'b000, "inv.run");
        drive_check(1'b1, 3'b000, "inv.c8");
        check("inv.last_c8", bus.light_cnt_last, 1);
        clock();

        // Freeze at sec_cnt=1, light_cnt=1 (GREEN cycle 5) for 5 cycles.
        step(1'b1, 3'b001, "frz.load");
        for (int i = 0; i < 5; i++) step(1'b1, 3'b000, "frz.run");
        for (int i = 0; i < 5; i++) begin
            drive_check(1'b0, 3'b000, "frz.off");
            check("frz.off_last", bus.light_cnt_last, 0);
            check("frz.off_pre", bus.second_cnt_pre_last, 0);
            clock();
        end
        step(1'b1, 3'b000, "frz.r0");
        step(1'b1, 3'b000, "frz.r1");
        drive_check(1'b1, 3'b000, "frz.r2");
        check("frz.last_early", bus.light_cnt_last, 0);
        clock();
        drive_check(1'b1, 3'b000, "frz.r3");
        check("frz.last_after3", bus.light_cnt_last, 1);
        clock();

        // Randomized traffic against the model.
        bad_pats[0] = 3'b011;
        bad_pats[1] = 3'b110;
        bad_pats[2] = 3'b101;
        bad_pats[3] = 3'b111;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rnd");
            end
            r = 3'b000;
            case ($urandom_range(0, 19))
                0:       r = 3'b001;
                1:       r = 3'b010;
                2:       r = 3'b100;
                3:       r = bad_pats[$urandom_range(0, 3)];
                default: r = 3'b000;
            endcase
            step(($urandom_range(0, 5) != 0), r, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/traffic_timer.md
Name: traffic_timer

Overview:
- Timing back-end for traffic_fsm. Consumes the FSM's per-phase load request `light_cnt_init` and produces the two terminal flags the FSM advances on: `light_cnt_last` and `second_cnt_pre_last`.
- Contains a clock-to-second prescaler and a per-phase seconds down-counter.
- Sits beside traffic_fsm in the traffic top level; outputs connect directly to the FSM inputs.

Parameters:
- LIGHT_STATE_WIDTH, 3, width of the one-hot light/load-request bus.
- CLK_PER_SEC, 50000000, clock cycles per second; must be >= 2.
- CNT_WIDTH, 8, width of the seconds counter.
- GREEN_SEC, 30, green phase duration in seconds (>= 1).
- YELLOW_SEC, 3, yellow phase duration in seconds (>= 1).
- RED_SEC, 20, red phase duration in seconds (>= 1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  counting enable, same signal that drives the FSM.
- light_cnt_init  in  LIGHT_STATE_WIDTH  one-hot load request: 001 loads GREEN_SEC, 010 loads YELLOW_SEC, 100 loads RED_SEC, 000 means no load.
- light_cnt_last  out  1  high while the final second of the current phase is running.
- second_cnt_pre_last  out  1  high for one cycle, one cycle before each second boundary.
- remain_sec  out  CNT_WIDTH  present only with TRAFFIC_TIMER_REMAIN_EN; see Optional Feature.

Behaviour:
- Reset (async, rst_n=0): `sec_cnt`=0, `light_cnt`=0, `active`=0, all outputs 0. Reset mid-phase aborts the phase; no flag may be asserted until the next load.
- Prescaler:
  - When en=1, `sec_cnt` counts 0..CLK_PER_SEC-1 and wraps to 0.
  - `tick` = en && (sec_cnt == CLK_PER_SEC-1).
  - second_cnt_pre_last = en && (sec_cnt == CLK_PER_SEC-2). Combinational from registers, no added latency.
- Load:
  - A valid one-hot `light_cnt_init` at a rising edge sets light_cnt <= duration-1, sec_cnt <= 0, active <= 1.
  - Load has priority over `tick` and over the en freeze; it is accepted even when en=0.
  - Invalid patterns (zero-hot is "no load"; multi-hot such as 011 or 111) are ignored: no state change beyond normal counting.
- Seconds counter:
  - On `tick` with no load: if light_cnt != 0, decrement it; if light_cnt == 0, hold at 0 (no wrap, saturate until the next load).
- Flag: light_cnt_last = en && active && (light_cnt == 0).
- Phase timing:
  - The FSM advances on the edge where both flags are high and asserts `light_cnt_init` in the following cycle.
  - The load therefore lands on the edge that would wrap `sec_cnt`.
  - Each phase lasts exactly duration × CLK_PER_SEC cycles, measured from load edge to load edge.
- en=0:
  - Both counters freeze.
  - Both flags are forced to 0.
  - Counting resumes from the frozen values when en returns to 1.
- Idle (active=0, en=1): the prescaler runs and pulses second_cnt_pre_last; light_cnt_last stays 0.
- Width rule: each duration must satisfy duration-1 < 2^CNT_WIDTH; violation is an elaboration error.

Optional Feature:
- Macro: TRAFFIC_TIMER_REMAIN_EN.
- Defined:
  - Port `remain_sec` is present.
  - remain_sec = active ? light_cnt + 1 : 0, computed at CNT_WIDTH bits and registered-free.
  - Intended for a countdown display.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package `traffic_pkg` holds:
  - LIGHT_GREEN=3'b001, LIGHT_YELLOW=3'b010, LIGHT_RED=3'b100;
  - LIGHT_STATE_WIDTH;
  - default durations;
  - CLK_PER_SEC default.
  - Shared with traffic_fsm.
- One natural sub-module, `sec_prescaler`: owns `sec_cnt`, `tick`, pre_last, and a synchronous clear used by load.

Test Plan (CLK_PER_SEC=4, GREEN_SEC=3, YELLOW_SEC=1, RED_SEC=2, CNT_WIDTH=4; cycle 0 = first cycle after the load edge):
- Reset: rst_n=0 asynchronously mid-cycle, then held → all outputs 0 immediately. Release with en=1, no load → second_cnt_pre_last high every 4th cycle (sec_cnt=2); light_cnt_last stays 0.
- Load GREEN: init=001 for one cycle → light_cnt=2 at cycle 0; 1 at cycle 4; 0 at cycle 8. light_cnt_last high cycles 8–11; both flags high at cycle 10. The next init, applied at cycle 11, loads at the cycle-12 edge, giving a 12-cycle phase.
- Load YELLOW: init=010 → light_cnt_last high from cycle 0; pre_last at cycle 2. Reload RED at the cycle-4 edge → light_cnt_last first high at cycle 4 of RED; both flags at cycle 6.
- Load priority and invalid request:
  - init=100 coincident with tick → load wins: light_cnt=1, sec_cnt=0.
  - init=011 → ignored: counters continue, light_cnt unchanged except by tick.
- en freeze: en=0 for 5 cycles at sec_cnt=1, light_cnt=1 → flags 0, counters held. After en=1, light_cnt reaches 0 after 3 more cycles.
- Saturation: no reload after last → light_cnt holds 0 and light_cnt_last stays high across ticks. With TRAFFIC_TIMER_REMAIN_EN: remain_sec=3,2,1 during GREEN, and 0 after reset.
